inst_fetcher: RTL and testbench
===============================

Name: inst_fetcher

Overview:
- Instruction fetch stage directly upstream of the decoder in the out-of-order core.
- Holds the architectural fetch PC and requests instruction words from the icache.
- Presents one fetched instruction at a time to the decoder (inst, inst_addr, start_decode).
- Advances on the decoder's issue_signal/next_pc, and redirects on ROB misprediction. Responses still in flight from a stale request are discarded.

Parameters:
RESET_PC, 32'h0, fetch PC loaded on reset.

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, synchronous, active-low (asserted when 0)
rdy_in  input  1  ready; when 0 all state is frozen
icache_req  output  1  fetch request, level
icache_addr  output  32  halfword-aligned fetch address
icache_valid  input  1  one-cycle pulse: icache_data corresponds to icache_addr
icache_data  input  32  32 bits starting at icache_addr (low 16 meaningful for compressed)
inst  output  32  instruction to decoder
inst_addr  output  32  address of inst
start_decode  output  1  inst/inst_addr valid, decoder may issue
next_pc  input  32  decoder's predicted successor PC (already muxes correct_pc)
issue_signal  input  1  decoder issued the presented instruction this cycle
jalr_stall  input  1  decoder stalled on JALR operand (informational; hold)
wrong_predicted  input  1  ROB flush
correct_pc  input  32  redirect target, valid with wrong_predicted

Behaviour:
- Reset: rst_in==0 at a posedge sets state=FETCH, pc=RESET_PC, drop_pc=0, inst=0, inst_addr=0. Reset has priority over rdy_in.
- While in reset, icache_req=0 and start_decode=0. The first request is raised in the cycle after rst_in returns to 1.
- rdy_in==0 (outside reset): no register changes. Outputs hold their values. icache_valid and issue_signal are ignored for that cycle; the icache must not pulse valid while rdy_in is low.
- Outputs are decoded from registers only: icache_req=(state==FETCH||state==DROP), icache_addr=pc, start_decode=(state==HOLD).
- Every PC load forces bit 0 to 0.
- Icache protocol: icache_addr stays stable while icache_req=1 until icache_valid is seen. Exactly one valid is returned per request.
- States and transitions (evaluated at posedge, rdy_in=1). Priority order within each state is as listed.
  - FETCH, wrong_predicted=1 and icache_valid=1: response dropped; pc=correct_pc; stay FETCH.
  - FETCH, wrong_predicted=1 and icache_valid=0: drop_pc=correct_pc; go DROP.
  - FETCH, icache_valid=1: inst=icache_data, inst_addr=pc; go HOLD.
  - FETCH, otherwise: stay FETCH.
  - DROP, wrong_predicted=1 and icache_valid=1: pc=correct_pc; go FETCH.
  - DROP, wrong_predicted=1 and icache_valid=0: drop_pc=correct_pc (newest redirect wins).
  - DROP, icache_valid=1: pc=drop_pc; go FETCH.
  - DROP, otherwise: wait.
  - HOLD, wrong_predicted=1: pc=correct_pc; go FETCH. Any issue_signal is ignored.
  - HOLD, issue_signal=1: pc=next_pc; go FETCH.
  - HOLD, otherwise (jalr_stall, rob/rs/lsb full): stay HOLD; inst and inst_addr unchanged.
- Latency:
  - icache_valid at cycle N gives start_decode=1 at N+1.
  - issue_signal at cycle M gives icache_req with the new pc at M+1.
  - Minimum 2 cycles per instruction with a 0-wait icache.
- inst is passed through unmodified. Compressed/32-bit length handling belongs to the decoder via next_pc. The fetcher does no PC arithmetic.

Test Plan:
- Reset with RESET_PC=0x100, 0-wait icache returning 0x00004501 at 0x100: cycle 1 icache_req=1, addr 0x100. Cycle 2 start_decode=1, inst=0x00004501, inst_addr=0x100. Issue with next_pc=0x102 → next addr 0x102.
- Decoder withholds issue_signal (jalr_stall=1) for 5 cycles: start_decode stays 1, inst and inst_addr unchanged, icache_req=0. On issue with next_pc=0x200 → next cycle addr 0x200.
- Icache with 3-cycle latency, pc=0x40; wrong_predicted with correct_pc=0x80 in wait cycle 1: icache_addr stays 0x40 until valid. Data is dropped, start_decode never asserts for 0x40, next request is 0x80.
- In DROP, two flushes (0x80, then 0xC0) before valid: fetch resumes at 0xC0.
- wrong_predicted coincident with icache_valid in FETCH (correct_pc=0x300): response dropped, next cycle addr 0x300, state FETCH.
- rdy_in=0 for 4 cycles mid-HOLD, then rst_in=0 for one cycle with rdy_in=0: state frozen during the rdy stall. Reset then takes effect: start_decode=0, pc=RESET_PC.

Source files
------------

// File: rtl/inst_fetcher.sv
// Instruction fetch stage: holds the fetch PC, requests words from the icache and
// presents one instruction at a time to the decoder. Responses to a request that was
// overtaken by a ROB flush are discarded.
module inst_fetcher #(
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        rdy_in,
   output logic        icache_req,
   output logic [31:0] icache_addr,
   input  logic        icache_valid,
   input  logic [31:0] icache_data,
   output logic [31:0] inst,
   output logic [31:0] inst_addr,
   output logic        start_decode,
   input  logic [31:0] next_pc,
   input  logic        issue_signal,
   input  logic        jalr_stall,
   input  logic        wrong_predicted,
   input  logic [31:0] correct_pc
);

   typedef enum logic [1:0] {
      StFetch = 2'd0,
      StDrop  = 2'd1,
      StHold  = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] drop_pc_q, drop_pc_d;
   logic [31:0] inst_q, inst_d;
   logic [31:0] inst_addr_q, inst_addr_d;
   // Low during reset and for the first cycle after it, so no request is raised while
   // reset is held even though the state already reads FETCH.
   logic        run_q;

   // jalr_stall only explains why the decoder withholds issue; HOLD covers it.
   logic unused_jalr;
   assign unused_jalr = jalr_stall;

   // All PC loads are halfword aligned.
   logic [31:0] correct_pc_al, next_pc_al;
   assign correct_pc_al = {correct_pc[31:1], 1'b0};
   assign next_pc_al    = {next_pc[31:1], 1'b0};

   // State register: synchronous reset wins over rdy_in; rdy_in low freezes everything.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q     <= StFetch;
         pc_q        <= {RESET_PC[31:1], 1'b0};
         drop_pc_q   <= 32'h0;
         inst_q      <= 32'h0;
         inst_addr_q <= 32'h0;
         run_q       <= 1'b0;
      end else if (rdy_in) begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         drop_pc_q   <= drop_pc_d;
         inst_q      <= inst_d;
         inst_addr_q <= inst_addr_d;
         run_q       <= 1'b1;
      end
   end

   // Next-state logic; flush has priority over a response or an issue in every state.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      drop_pc_d   = drop_pc_q;
      inst_d      = inst_q;
      inst_addr_d = inst_addr_q;
      if (run_q) begin
         unique case (state_q)
            StFetch: begin
               if (wrong_predicted && icache_valid) begin
                  pc_d = correct_pc_al;
               end else if (wrong_predicted) begin
                  drop_pc_d = correct_pc_al;
                  state_d   = StDrop;
               end else if (icache_valid) begin
                  inst_d      = icache_data;
                  inst_addr_d = pc_q;
                  state_d     = StHold;
               end
            end
            StDrop: begin
               if (wrong_predicted && icache_valid) begin
                  pc_d    = correct_pc_al;
                  state_d = StFetch;
               end else if (wrong_predicted) begin
                  drop_pc_d = correct_pc_al;
               end else if (icache_valid) begin
                  pc_d    = drop_pc_q;
                  state_d = StFetch;
               end
            end
            StHold: begin
               if (wrong_predicted) begin
                  pc_d    = correct_pc_al;
                  state_d = StFetch;
               end else if (issue_signal) begin
                  pc_d    = next_pc_al;
                  state_d = StFetch;
               end
            end
            default: state_d = StFetch;
         endcase
      end
   end

   // Outputs decode registered state only.
   always_comb begin
      icache_req   = run_q && (state_q == StFetch || state_q == StDrop);
      icache_addr  = pc_q;
      start_decode = run_q && (state_q == StHold);
      inst         = inst_q;
      inst_addr    = inst_addr_q;
   end

endmodule

// File: tb/tb_inst_fetcher.sv
// Randomised bench for inst_fetcher: the bench plays both icache and decoder, keeps the
// expected next presented address in a scoreboard queue and checks each presentation.
module tb_inst_fetcher;

   localparam logic [31:0] RPC = 32'h100;

   logic        clk = 1'b0;
   logic        rst_n, rdy;
   logic        req, icache_valid, start, issue_signal, jalr_stall, wrong_predicted;
   logic [31:0] addr, icache_data, inst, inst_addr, next_pc, correct_pc;

   always #5 clk = ~clk;

   inst_fetcher #(.RESET_PC(RPC)) dut (
      .clk_in         (clk),
      .rst_in         (rst_n),
      .rdy_in         (rdy),
      .icache_req     (req),
      .icache_addr    (addr),
      .icache_valid   (icache_valid),
      .icache_data    (icache_data),
      .inst           (inst),
      .inst_addr      (inst_addr),
      .start_decode   (start),
      .next_pc        (next_pc),
      .issue_signal   (issue_signal),
      .jalr_stall     (jalr_stall),
      .wrong_predicted(wrong_predicted),
      .correct_pc     (correct_pc)
   );

   int          vectors = 0;
   int          errors = 0;
   int          presents = 0;
   logic [31:0] exp_q[$];
   bit          mon_en = 0, pend_present = 0, prev_start = 0;
   bit          outstanding = 0, stale = 0;
   logic [31:0] req_addr = 32'h0;
   int          lat = 0;

   // Icache contents: distinct word per address (addresses stay below 64K).
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5a3c, ~a[15:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_bit(input string name, input logic act, input logic exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_q.push_back(RPC);
      outstanding  = 0;
      stale        = 0;
      pend_present = 0;
   endtask

   // Drive one cycle of icache/decoder behaviour and update the scoreboard.
   task automatic drive(input bit allow_stall);
      rdy             = !(allow_stall && $urandom_range(0, 9) == 0);
      icache_valid    = 1'b0;
      wrong_predicted = 1'b0;
      issue_signal    = 1'b0;
      jalr_stall      = 1'b0;
      pend_present    = 0;
      icache_data     = $urandom;
      next_pc         = {16'h0, 16'($urandom)};
      correct_pc      = {16'h0, 16'($urandom)};
      if (!rdy) return;
      if (req) begin
         if (!outstanding) begin
            outstanding = 1;
            stale       = 0;
            req_addr    = addr;
            lat         = $urandom_range(0, 3);
            if (exp_q.size() == 0) begin
               vectors++;
               errors++;
               $display("FAIL req_start: request at %h with no expected address", addr);
            end else begin
               check("req_addr", addr, exp_q[0]);
            end
         end else begin
            check("addr_stable", addr, req_addr);
         end
         if (lat == 0) begin
            icache_valid = 1'b1;
            icache_data  = mem_word(addr);
         end else begin
            lat--;
         end
      end
      if (start) begin
         issue_signal = ($urandom_range(0, 2) == 0);
         jalr_stall   = !issue_signal && ($urandom_range(0, 1) == 1);
      end
      wrong_predicted = ($urandom_range(0, 11) == 0);
      if (wrong_predicted) begin
         if (outstanding) stale = 1;
         exp_q.delete();
         exp_q.push_back(correct_pc & ~32'h1);
      end else if (issue_signal) begin
         exp_q.push_back(next_pc & ~32'h1);
      end
      if (icache_valid) begin
         pend_present = !stale;
         outstanding  = 0;
      end
   endtask

   // Monitor: every new presentation must follow a live response and match the scoreboard.
   initial begin
      logic [31:0] a;
      forever begin
         @(posedge clk);
         #1;
         if (mon_en) begin
            check_bit("present_timing", start && !prev_start, pend_present);
            if (start && !prev_start) begin
               presents++;
               check_bit("req_in_hold", req, 1'b0);
               if (exp_q.size() == 0) begin
                  vectors++;
                  errors++;
                  $display("FAIL present: inst_addr %h presented, scoreboard empty", inst_addr);
               end else begin
                  a = exp_q.pop_front();
                  check("inst_addr", inst_addr, a);
                  check("inst", inst, mem_word(a));
               end
            end
         end
         prev_start = start;
      end
   end

   initial begin
      logic [31:0] held_inst, held_addr;
      bit          found;
      rst_n = 1'b0; rdy = 1'b1; icache_valid = 1'b0; icache_data = 32'h0;
      issue_signal = 1'b0; jalr_stall = 1'b0; wrong_predicted = 1'b0;
      next_pc = 32'h0; correct_pc = 32'h0;
      repeat (3) begin
         @(negedge clk);
         check_bit("reset_req", req, 1'b0);
         check_bit("reset_start", start, 1'b0);
      end
      rst_n = 1'b1;
      model_reset();
      mon_en = 1;
      @(negedge clk);
      check_bit("first_req", req, 1'b1);
      check("first_addr", addr, RPC);
      drive(0);
      repeat (4000) begin
         @(negedge clk);
         drive(1);
      end

      // Freeze mid-HOLD, then reset while frozen.
      found = 0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (start) begin
            found = 1;
            break;
         end
         drive(0);
      end
      if (!found) begin
         vectors++;
         errors++;
         $display("FAIL hold_wait: no presentation within 200 cycles");
      end
      rdy = 1'b0; icache_valid = 1'b0; wrong_predicted = 1'b0; issue_signal = 1'b1;
      pend_present = 0;
      held_inst = inst;
      held_addr = inst_addr;
      repeat (4) begin
         @(negedge clk);
         check_bit("stall_start", start, found);
         check_bit("stall_req", req, 1'b0);
         check("stall_inst", inst, held_inst);
         check("stall_inst_addr", inst_addr, held_addr);
      end
      rst_n = 1'b0;
      @(negedge clk);
      check_bit("rst_frozen_start", start, 1'b0);
      check_bit("rst_frozen_req", req, 1'b0);
      check("rst_frozen_pc", addr, RPC);
      check("rst_frozen_inst", inst, 32'h0);
      check("rst_frozen_inst_addr", inst_addr, 32'h0);
      rst_n = 1'b1; rdy = 1'b1; issue_signal = 1'b0;
      model_reset();
      @(negedge clk);
      check_bit("rerun_req", req, 1'b1);
      check("rerun_addr", addr, RPC);
      drive(0);
      repeat (500) begin
         @(negedge clk);
         drive(1);
      end
      @(negedge clk);
      rdy = 1'b0;
      @(negedge clk);
      check_bit("enough_presentations", presents > 200, 1'b1);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
